// File: rtl/hex_mon_pkg.sv
// Shared constants, state encoding and time payload for hex_time_monitor.
// Seven-segment patterns are active-low with bit0 = segment a.
package hex_mon_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned SNAP_W     = SEG_W * NUM_DIGITS;
  localparam int unsigned SEC_W      = 6;
  localparam int unsigned MIN_W      = 6;
  localparam int unsigned HOUR_W     = 5;
  localparam int unsigned HOUR_RAW_W = 7;
  localparam int unsigned ERR_CNT_W  = 16;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } hms_t;

  // Time one second after t, wrapping hour_max back to zero.
  function automatic hms_t next_second(input hms_t t, input logic [HOUR_W-1:0] hour_max);
    hms_t nxt;
    nxt = t;
    if (t.sec == SEC_W'(59)) begin
      nxt.sec = '0;
      if (t.min == MIN_W'(59)) begin
        nxt.min = '0;
        if (t.hour == hour_max) begin
          nxt.hour = '0;
        end else begin
          nxt.hour = t.hour + HOUR_W'(1);
        end
      end else begin
        nxt.min = t.min + MIN_W'(1);
      end
    end else begin
      nxt.sec = t.sec + SEC_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low 7-segment glyph into a BCD digit.
// o_legal_c is low for any pattern other than the ten digit glyphs.
module seg7_to_bcd
  import hex_mon_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic [BCD_W-1:0] o_bcd_c,
  output logic             o_legal_c
);

  always_comb begin
    o_bcd_c   = '0;
    o_legal_c = 1'b1;
    case (i_seg)
      SEG_0:   o_bcd_c = BCD_W'(0);
      SEG_1:   o_bcd_c = BCD_W'(1);
      SEG_2:   o_bcd_c = BCD_W'(2);
      SEG_3:   o_bcd_c = BCD_W'(3);
      SEG_4:   o_bcd_c = BCD_W'(4);
      SEG_5:   o_bcd_c = BCD_W'(5);
      SEG_6:   o_bcd_c = BCD_W'(6);
      SEG_7:   o_bcd_c = BCD_W'(7);
      SEG_8:   o_bcd_c = BCD_W'(8);
      SEG_9:   o_bcd_c = BCD_W'(9);
      default: o_legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/hex_time_monitor.sv
// Recovers and checks HH:MM:SS from six 7-segment buses driven by a BCD timer.
// Define HEX_MON_ERR_CNT_EN to build the saturating error counter on o_err_cnt.
module hex_time_monitor
  import hex_mon_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned HOUR_MAX      = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEG_W-1:0]     i_HEX0,
  input  logic [SEG_W-1:0]     i_HEX1,
  input  logic [SEG_W-1:0]     i_HEX2,
  input  logic [SEG_W-1:0]     i_HEX3,
  input  logic [SEG_W-1:0]     i_HEX4,
  input  logic [SEG_W-1:0]     i_HEX5,
  output logic [SEC_W-1:0]     o_sec,
  output logic [MIN_W-1:0]     o_min,
  output logic [HOUR_W-1:0]    o_hour,
  output logic                 o_valid,
  output logic                 o_tick,
  output logic                 o_err_glyph,
  output logic                 o_err_seq,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [SNAP_W-1:0] SNAP_BLANK = {NUM_DIGITS{SEG_BLANK}};

  logic [SNAP_W-1:0] snap_c;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [SNAP_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  hms_t              time_q, time_d;
  logic              valid_q, valid_d;
  logic              tick_q, tick_d;
  logic              err_glyph_q, err_glyph_d;
  logic              err_seq_q, err_seq_d;

  logic                  stable_c;
  logic                  eval_c;
  logic [BCD_W-1:0]      bcd_c [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] glyph_ok_c;
  logic [SEC_W-1:0]      sec_raw_c;
  logic [MIN_W-1:0]      min_raw_c;
  logic [HOUR_RAW_W-1:0] hour_raw_c;
  logic                  range_ok_c;
  logic                  legal_c;
  hms_t                  snap_time_c;
  hms_t                  next_time_c;

  assign snap_c = {i_HEX5, i_HEX4, i_HEX3, i_HEX2, i_HEX1, i_HEX0};

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
    seg7_to_bcd u_dec (
      .i_seg     (snap_q[gi*SEG_W +: SEG_W]),
      .o_bcd_c   (bcd_c[gi]),
      .o_legal_c (glyph_ok_c[gi])
    );
  end

  // Field values are only meaningful when every glyph decoded legally.
  always_comb begin
    sec_raw_c  = SEC_W'(bcd_c[1]) * SEC_W'(10) + SEC_W'(bcd_c[0]);
    min_raw_c  = MIN_W'(bcd_c[3]) * MIN_W'(10) + MIN_W'(bcd_c[2]);
    hour_raw_c = HOUR_RAW_W'(bcd_c[5]) * HOUR_RAW_W'(10) + HOUR_RAW_W'(bcd_c[4]);
    range_ok_c = (bcd_c[1] <= BCD_W'(5)) && (bcd_c[3] <= BCD_W'(5)) &&
                 (hour_raw_c <= HOUR_RAW_W'(HOUR_MAX));
    legal_c    = (&glyph_ok_c) && range_ok_c;
    snap_time_c.hour = HOUR_W'(hour_raw_c);
    snap_time_c.min  = min_raw_c;
    snap_time_c.sec  = sec_raw_c;
    next_time_c      = next_second(time_q, HOUR_W'(HOUR_MAX));
  end

  // Stability filter: evaluate a snapshot once it has been held long enough and is new.
  always_comb begin
    snap_d   = snap_c;
    cnt_d    = cnt_q;
    stable_c = (cnt_q == CNT_STABLE);
    if (snap_c != snap_q) begin
      cnt_d = '0;
    end else if (!stable_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    eval_c = stable_c && (snap_q != last_q);
    last_d = eval_c ? snap_q : last_q;
  end

  // Next-state and output logic for the tracking FSM.
  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    valid_d     = valid_q;
    tick_d      = 1'b0;
    err_glyph_d = 1'b0;
    err_seq_d   = 1'b0;
    if (eval_c) begin
      case (state_q)
        ST_IDLE: begin
          if (legal_c) begin
            time_d  = snap_time_c;
            valid_d = 1'b1;
            state_d = ST_TRACK;
          end else begin
            err_glyph_d = 1'b1;
          end
        end
        ST_TRACK: begin
          if (!legal_c) begin
            err_glyph_d = 1'b1;
            valid_d     = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            time_d = snap_time_c;
            if (snap_time_c == next_time_c) begin
              tick_d = 1'b1;
            end else begin
              err_seq_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q      <= SNAP_BLANK;
      last_q      <= SNAP_BLANK;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      time_q      <= '0;
      valid_q     <= 1'b0;
      tick_q      <= 1'b0;
      err_glyph_q <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      time_q      <= time_d;
      valid_q     <= valid_d;
      tick_q      <= tick_d;
      err_glyph_q <= err_glyph_d;
      err_seq_q   <= err_seq_d;
    end
  end

  assign o_sec       = time_q.sec;
  assign o_min       = time_q.min;
  assign o_hour      = time_q.hour;
  assign o_valid     = valid_q;
  assign o_tick      = tick_q;
  assign o_err_glyph = err_glyph_q;
  assign o_err_seq   = err_seq_q;

`ifdef HEX_MON_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counts with the pulse it accompanies; sticks at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((err_glyph_d || err_seq_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_cnt = err_cnt_q;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_hex_time_monitor.sv
// Scoreboard bench for hex_time_monitor: expected events are queued at drive
// time and matched by a negedge monitor as the DUT emits them.
module tb_hex_time_monitor;

  localparam int S = 4;
  localparam int HOLD = 10;
  localparam int EV_LOAD = 0;
  localparam int EV_TICK = 1;
  localparam int EV_SEQ = 2;
  localparam int EV_GLYPH = 3;
`ifdef HEX_MON_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    int kind;
    int hour;
    int min;
    int sec;
    bit valid;
    int cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [5:0]  o_sec, o_min;
  logic [4:0]  o_hour;
  logic        o_valid, o_tick, o_err_glyph, o_err_seq;
  logic [15:0] o_err_cnt;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  cur_h = 0, cur_m = 0, cur_s = 0;
  int  exp_err = 0;
  bit  prev_valid = 1'b0;
  int  mon_kind;
  ev_t mon_e;

  hex_time_monitor #(.STABLE_CYCLES(S), .HOUR_MAX(23)) dut (
    .clk(clk), .rst(rst),
    .i_HEX0(hex0), .i_HEX1(hex1), .i_HEX2(hex2),
    .i_HEX3(hex3), .i_HEX4(hex4), .i_HEX5(hex5),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_valid(o_valid),
    .o_tick(o_tick), .o_err_glyph(o_err_glyph), .o_err_seq(o_err_seq),
    .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Monitor: every output event pops and matches the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      checks++;
      if (int'(o_tick) + int'(o_err_seq) + int'(o_err_glyph) > 1) begin
        errors++;
        $display("FAIL pulse_onehot: tick=%0b seq=%0b glyph=%0b, at most one required",
                 o_tick, o_err_seq, o_err_glyph);
      end
      mon_kind = -1;
      if (o_tick) mon_kind = EV_TICK;
      else if (o_err_seq) mon_kind = EV_SEQ;
      else if (o_err_glyph) mon_kind = EV_GLYPH;
      else if (o_valid && !prev_valid) mon_kind = EV_LOAD;
      prev_valid = o_valid;
      if (mon_kind >= 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got kind=%0d %0d:%0d:%0d at cyc %0d, none expected",
                   mon_kind, o_hour, o_min, o_sec, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind != mon_kind || mon_e.hour != int'(o_hour) ||
              mon_e.min != int'(o_min) || mon_e.sec != int'(o_sec) ||
              mon_e.valid !== o_valid || mon_e.cyc != cyc) begin
            errors++;
            $display("FAIL event: got kind=%0d %0d:%0d:%0d valid=%0b cyc=%0d, expected kind=%0d %0d:%0d:%0d valid=%0b cyc=%0d",
                     mon_kind, o_hour, o_min, o_sec, o_valid, cyc,
                     mon_e.kind, mon_e.hour, mon_e.min, mon_e.sec, mon_e.valid, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic set_blank();
    hex0 = 7'h7f; hex1 = 7'h7f; hex2 = 7'h7f;
    hex3 = 7'h7f; hex4 = 7'h7f; hex5 = 7'h7f;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    set_blank();
    exp_q.delete();
    exp_err = 0;
    cur_h = 0; cur_m = 0; cur_s = 0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive a time and queue the event it must cause S+1 edges later.
  task automatic drive(input int h, input int m, input int s, input int kind);
    ev_t e;
    @(posedge clk); #1;
    hex0 = seg(s % 10); hex1 = seg(s / 10);
    hex2 = seg(m % 10); hex3 = seg(m / 10);
    hex4 = seg(h % 10); hex5 = seg(h / 10);
    if (kind != EV_GLYPH) begin
      cur_h = h; cur_m = m; cur_s = s;
    end
    if (kind == EV_SEQ || kind == EV_GLYPH) exp_err++;
    e.kind = kind; e.hour = cur_h; e.min = cur_m; e.sec = cur_s;
    e.valid = (kind != EV_GLYPH); e.cyc = cyc + 1 + S;
    exp_q.push_back(e);
    repeat (HOLD - 1) @(posedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({o_valid, o_tick, o_err_glyph, o_err_seq} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {o_valid, o_tick, o_err_glyph, o_err_seq});
    end
    checks++;
    if ({o_hour, o_min, o_sec} !== 17'd0) begin
      errors++;
      $display("FAIL reset_time: got %0d:%0d:%0d, required 0:0:0", o_hour, o_min, o_sec);
    end
    checks++;
    if (o_err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_err_cnt: got %0d, required 0", o_err_cnt);
    end
    release_reset();
    repeat (12) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL blank_idle: valid=%0b pending=%0d, required 0 and 0", o_valid, exp_q.size());
    end
  endtask

  task automatic test_first_load();
    drive(0, 0, 0, EV_LOAD);
    drive(0, 0, 1, EV_TICK);
    drive(0, 0, 2, EV_TICK);
    @(negedge clk);
    checks++;
    if (o_sec !== 6'd2 || o_valid !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL first_load: sec=%0d valid=%0b pending=%0d, required 2 1 0", o_sec, o_valid, exp_q.size());
    end
  endtask

  task automatic test_midnight_wrap();
    drive(23, 59, 59, EV_SEQ);
    drive(0, 0, 0, EV_TICK);
    @(negedge clk);
    checks++;
    if ({o_hour, o_min, o_sec} !== 17'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midnight_wrap: got %0d:%0d:%0d pending=%0d, required 0:0:0 0", o_hour, o_min, o_sec, exp_q.size());
    end
  endtask

  task automatic test_seq_error();
    drive(12, 30, 10, EV_SEQ);
    drive(12, 30, 15, EV_SEQ);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_sec !== 6'd15) begin
      errors++;
      $display("FAIL seq_resync: valid=%0b sec=%0d, required 1 15", o_valid, o_sec);
    end
    drive(12, 30, 16, EV_TICK);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL seq_pending: got %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_glyph();
    int exp_cnt;
    drive(12, 30, 66, EV_GLYPH);
    drive(24, 0, 0, EV_GLYPH);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_hour !== 5'd12 || o_sec !== 6'd16) begin
      errors++;
      $display("FAIL glyph_hold: valid=%0b %0d:%0d:%0d, required 0 and 12:30:16", o_valid, o_hour, o_min, o_sec);
    end
    drive(8, 15, 0, EV_LOAD);
    @(negedge clk);
    exp_cnt = CNT_EN ? exp_err : 0;
    checks++;
    if (int'(o_err_cnt) != exp_cnt || exp_q.size() != 0) begin
      errors++;
      $display("FAIL err_cnt: got %0d pending=%0d, required %0d 0", o_err_cnt, exp_q.size(), exp_cnt);
    end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1;
    hex0 = seg(7);
    repeat (S - 1) @(posedge clk);
    #1 hex0 = seg(0);
    repeat (20) @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_min !== 6'd15 || o_sec !== 6'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch: valid=%0b %0d:%0d:%0d, required 1 and 8:15:0", o_valid, o_hour, o_min, o_sec);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({o_valid, o_hour, o_min, o_sec, o_err_cnt} !== 34'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%0b %0d:%0d:%0d cnt=%0d, required all 0",
               o_valid, o_hour, o_min, o_sec, o_err_cnt);
    end
    repeat (2) @(posedge clk);
    release_reset();
    drive(8, 15, 0, EV_LOAD);
    drive(8, 15, 1, EV_TICK);
    drive(8, 15, 2, EV_TICK);
    @(negedge clk);
    checks++;
    if (o_sec !== 6'd2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: sec=%0d pending=%0d, required 2 0", o_sec, exp_q.size());
    end
  endtask

  initial begin
    set_blank();
    test_reset();
    test_first_load();
    test_midnight_wrap();
    test_seq_error();
    test_glyph();
    test_glitch();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
